// File: rtl/hs_access_arbiter_if.sv
// Signal bundle between the high-score/OSD/core side and hs_access_arbiter.
// The arbiter uses the slave view. A driver or test harness uses the master view.
interface hs_access_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              pause_btn;
  logic              osd_open;
  logic              osd_pause_en;
  logic              vblank;
  logic              hs_req;
  logic              hs_grant;
  logic              hs_timeout;
  logic [ADDR_W-1:0] hs_addr;
  logic [7:0]        hs_din;
  logic              hs_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic              cpu_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic              pause;
  logic              dim_video;

  modport master (
    output pause_btn, osd_open, osd_pause_en, vblank, hs_req,
    output hs_addr, hs_din, hs_we, cpu_addr, cpu_din, cpu_we,
    input  hs_grant, hs_timeout, ram_addr, ram_din, ram_we, pause, dim_video
  );

  modport slave (
    input  pause_btn, osd_open, osd_pause_en, vblank, hs_req,
    input  hs_addr, hs_din, hs_we, cpu_addr, cpu_din, cpu_we,
    output hs_grant, hs_timeout, ram_addr, ram_din, ram_we, pause, dim_video
  );
endinterface

// File: rtl/hs_access_arbiter.sv
// Pause merging and vblank-gated hand-over of the shared work RAM to the high-score side.
// This block also contains the watchdog on the grant and the dim-on-long-user-pause timer.
module hs_access_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int SETTLE_CYCLES = 16,
  parameter int HOLD_MAX      = 65535,
  parameter int DIM_CYCLES    = 300000000
) (
  input  logic               clk,
  input  logic               reset,
  hs_access_arbiter_if.slave bus
);

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam int DIM_W  = $clog2(DIM_CYCLES + 1);

  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_MAX - 1);
  localparam logic [DIM_W-1:0]  DIM_LIMIT   = DIM_W'(DIM_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VBL,
    ST_SETTLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timeout_q, timeout_d;
  logic               grant_q, grant_d;
  logic               btn_q;
  logic               vblank_q;
  logic               user_pause_q, user_pause_d;
  logic [DIM_W-1:0]   dim_cnt_q, dim_cnt_d;
  logic               dim_video_q, dim_video_d;
  logic               pause_q, pause_d;
  logic               vblank_rise;

  assign vblank_rise = bus.vblank & ~vblank_q;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    hold_d    = hold_q;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.hs_req) begin
          state_d   = ST_WAIT_VBL;
          timeout_d = 1'b0;
        end
      end
      ST_WAIT_VBL: begin
        // A request withdrawn in the same cycle as the vblank edge is treated as withdrawn.
        if (!bus.hs_req) begin
          state_d = ST_IDLE;
        end else if (vblank_rise) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!bus.hs_req) begin
          state_d = ST_IDLE;
        end else if (settle_q == '0) begin
          state_d = ST_GRANT;
          hold_d  = '0;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_GRANT: begin
        // A normal release wins over a watchdog hit that lands on the same cycle.
        if (!bus.hs_req) begin
          state_d = ST_RELEASE;
        end else if (hold_q == HOLD_LAST) begin
          state_d   = ST_RELEASE;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!bus.hs_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    grant_d      = (state_d == ST_GRANT);
    user_pause_d = user_pause_q ^ (bus.pause_btn & ~btn_q);
    dim_cnt_d    = '0;
    if (user_pause_q) begin
      dim_cnt_d = (dim_cnt_q >= DIM_LIMIT) ? DIM_LIMIT : dim_cnt_q + DIM_W'(1);
    end
    dim_video_d  = (dim_cnt_q >= DIM_LIMIT);
    pause_d      = user_pause_q | (bus.osd_open & bus.osd_pause_en) | (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      hold_q       <= '0;
      timeout_q    <= 1'b0;
      grant_q      <= 1'b0;
      btn_q        <= 1'b0;
      vblank_q     <= 1'b0;
      user_pause_q <= 1'b0;
      dim_cnt_q    <= '0;
      dim_video_q  <= 1'b0;
      pause_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      hold_q       <= hold_d;
      timeout_q    <= timeout_d;
      grant_q      <= grant_d;
      btn_q        <= bus.pause_btn;
      vblank_q     <= bus.vblank;
      user_pause_q <= user_pause_d;
      dim_cnt_q    <= dim_cnt_d;
      dim_video_q  <= dim_video_d;
      pause_q      <= pause_d;
    end
  end

  // grant_q always equals (state_q == ST_GRANT), so it doubles as the RAM mux select.
  assign bus.hs_grant   = grant_q;
  assign bus.hs_timeout = timeout_q;
  assign bus.pause      = pause_q;
  assign bus.dim_video  = dim_video_q;
  assign bus.ram_addr   = grant_q ? bus.hs_addr : bus.cpu_addr;
  assign bus.ram_din    = grant_q ? bus.hs_din  : bus.cpu_din;
  assign bus.ram_we     = grant_q ? bus.hs_we   : bus.cpu_we;

endmodule

// File: tb/tb_hs_access_arbiter.sv
// Bench for hs_access_arbiter: vector table, corner-case sequences, then random traffic.
// The random traffic is checked against a cycle model derived from the behavioural rules.
module tb_hs_access_arbiter;

  localparam int AW     = 12;
  localparam int SETTLE = 16;
  localparam int HOLD   = 100;
  localparam int DIM    = 50;

  localparam int P_IDLE = 0, P_WAIT = 1, P_SETTLE = 2, P_GRANT = 3, P_RELEASE = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hs_access_arbiter_if #(.ADDR_W(AW)) bus ();

  hs_access_arbiter #(
    .ADDR_W(AW), .SETTLE_CYCLES(SETTLE), .HOLD_MAX(HOLD), .DIM_CYCLES(DIM)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic btn_q;
    logic user;
    logic vbl_q;
    logic timeout;
    logic pause;
    logic dim;
    int   phase;
    int   t_settle;   // settle cycles spent so far
    int   n_grant;    // grant cycles spent so far
    int   dimcnt;
  } model_t;

  model_t m;

  function automatic model_t step(model_t s, logic btn, logic osd, logic osd_en,
                                  logic vbl, logic req);
    model_t n = s;
    n.btn_q  = btn;
    n.user   = s.user ^ (btn & ~s.btn_q);
    n.dimcnt = s.user ? ((s.dimcnt < DIM) ? s.dimcnt + 1 : DIM) : 0;
    n.dim    = (s.dimcnt >= DIM);
    n.pause  = s.user | (osd & osd_en) | (s.phase != P_IDLE);
    n.vbl_q  = vbl;
    case (s.phase)
      P_IDLE:
        if (req) begin n.phase = P_WAIT; n.timeout = 1'b0; end
      P_WAIT:
        if (!req) n.phase = P_IDLE;
        else if (vbl && !s.vbl_q) begin n.phase = P_SETTLE; n.t_settle = 1; end
      P_SETTLE:
        if (!req) n.phase = P_IDLE;
        else if (s.t_settle == SETTLE) begin n.phase = P_GRANT; n.n_grant = 1; end
        else n.t_settle = s.t_settle + 1;
      P_GRANT:
        if (!req) n.phase = P_RELEASE;
        else if (s.n_grant == HOLD) begin n.phase = P_RELEASE; n.timeout = 1'b1; end
        else n.n_grant = s.n_grant + 1;
      default:
        if (!req) n.phase = P_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else m <= step(m, bus.pause_btn, bus.osd_open, bus.osd_pause_en, bus.vblank, bus.hs_req);
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic btn, osd_open, osd_en, req, vbl;
    int   n;
    logic exp_pause, exp_grant, exp_dim;
  } vec_t;

  vec_t vecs[16];

  task automatic wait_grant(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.hs_grant) begin k = i; break; end
    end
  endtask

  int k, cnt, bad;

  initial begin
    vecs[0]  = '{0,0,0,0,0,  2, 0,0,0};
    vecs[1]  = '{1,0,0,0,0,  2, 1,0,0};
    vecs[2]  = '{0,0,0,0,0, 60, 1,0,1};
    vecs[3]  = '{1,0,0,0,0,  3, 0,0,0};
    vecs[4]  = '{0,1,0,0,0,  2, 0,0,0};
    vecs[5]  = '{0,1,1,0,0,  2, 1,0,0};
    vecs[6]  = '{1,1,1,0,0,  3, 1,0,0};
    vecs[7]  = '{0,0,0,0,0,  2, 1,0,0};
    vecs[8]  = '{1,0,0,0,0,  3, 0,0,0};
    vecs[9]  = '{0,0,0,1,0,  2, 1,0,0};
    vecs[10] = '{0,0,0,1,1, 16, 1,0,0};
    vecs[11] = '{0,0,0,1,1,  1, 1,1,0};
    vecs[12] = '{0,0,0,1,1,  5, 1,1,0};
    vecs[13] = '{0,0,0,0,1,  1, 1,0,0};
    vecs[14] = '{0,0,0,0,1,  1, 1,0,0};
    vecs[15] = '{0,0,0,0,1,  1, 0,0,0};

    reset = 1'b1;
    bus.pause_btn = 0; bus.osd_open = 0; bus.osd_pause_en = 0;
    bus.vblank = 0; bus.hs_req = 0;
    bus.hs_addr = 12'h123; bus.hs_din = 8'h5A; bus.hs_we = 0;
    bus.cpu_addr = 12'h0AB; bus.cpu_din = 8'h33; bus.cpu_we = 0;
    repeat (3) @(negedge clk);
    check("reset_pause", bus.pause, 0);
    check("reset_grant", bus.hs_grant, 0);
    check("reset_timeout", bus.hs_timeout, 0);
    check("reset_dim", bus.dim_video, 0);
    check("reset_ram_addr", bus.ram_addr, 12'h0AB);
    reset = 1'b0;
    $display("reset released: pause=%0b grant=%0b", bus.pause, bus.hs_grant);

    for (int i = 0; i < 16; i++) begin
      bus.pause_btn = vecs[i].btn; bus.osd_open = vecs[i].osd_open;
      bus.osd_pause_en = vecs[i].osd_en; bus.hs_req = vecs[i].req; bus.vblank = vecs[i].vbl;
      repeat (vecs[i].n) @(negedge clk);
      check($sformatf("vec%0d_pause", i), bus.pause, vecs[i].exp_pause);
      check($sformatf("vec%0d_grant", i), bus.hs_grant, vecs[i].exp_grant);
      check($sformatf("vec%0d_dim", i), bus.dim_video, vecs[i].exp_dim);
      check($sformatf("vec%0d_addr", i), bus.ram_addr, vecs[i].exp_grant ? 12'h123 : 12'h0AB);
      $display("vec %0d: pause=%0b grant=%0b dim=%0b", i, bus.pause, bus.hs_grant, bus.dim_video);
    end

    // Request while already inside vblank: a fresh rising edge is needed.
    bus.vblank = 1; bus.hs_req = 1;
    bad = 0;
    repeat (25) begin @(negedge clk); if (bus.hs_grant) bad++; end
    bus.vblank = 0;
    repeat (3) begin @(negedge clk); if (bus.hs_grant) bad++; end
    check("inside_vblank_no_grant", bad, 0);
    bus.vblank = 1;
    wait_grant(k);
    check("vblank_to_grant_cycles", k, SETTLE + 1);
    bus.cpu_we = 1; bus.hs_we = 0; #1;
    check("grant_ram_addr", bus.ram_addr, 12'h123);
    check("grant_cpu_we_ignored", bus.ram_we, 0);
    check("grant_ram_din", bus.ram_din, 8'h5A);
    bus.hs_we = 1; #1;
    check("grant_hs_we", bus.ram_we, 1);
    bus.hs_req = 0; bus.hs_we = 0;
    @(negedge clk);
    check("drop_grant_low", bus.hs_grant, 0);
    check("drop_cpu_owns", bus.ram_addr, 12'h0AB);
    check("drop_cpu_we_passes", bus.ram_we, 1);
    bus.cpu_we = 0;
    repeat (2) @(negedge clk);
    check("drop_pause_low", bus.pause, 0);
    $display("seq vblank-held: grant after %0d cycles", k);

    // Request dropped part-way through the settle window.
    bus.vblank = 0; bus.hs_req = 1;
    repeat (3) @(negedge clk);
    bus.vblank = 1;
    repeat (5) @(negedge clk);
    bus.hs_req = 0;
    @(negedge clk);
    check("settle_drop_pause_1", bus.pause, 1);
    @(negedge clk);
    check("settle_drop_pause_0", bus.pause, 0);
    bad = 0;
    repeat (20) begin @(negedge clk); if (bus.hs_grant) bad++; end
    check("settle_drop_no_grant", bad, 0);
    $display("seq settle-drop: grant cycles seen %0d", bad);

    // Watchdog: request held past the grant limit.
    bus.vblank = 0; bus.hs_req = 1;
    repeat (3) @(negedge clk);
    bus.vblank = 1;
    wait_grant(k);
    check("wd_grant_seen", k, SETTLE + 1);
    cnt = (k > 0) ? 1 : 0;
    for (int i = 0; i < 300 && k > 0; i++) begin
      @(negedge clk);
      if (bus.hs_grant) cnt++;
      else break;
    end
    check("wd_grant_cycles", cnt, HOLD);
    check("wd_timeout_set", bus.hs_timeout, 1);
    check("wd_pause_held", bus.pause, 1);
    repeat (10) @(negedge clk);
    check("wd_release_grant", bus.hs_grant, 0);
    check("wd_release_timeout", bus.hs_timeout, 1);
    check("wd_release_pause", bus.pause, 1);
    bus.hs_req = 0;
    @(negedge clk);
    check("wd_end_pause_1", bus.pause, 1);
    @(negedge clk);
    check("wd_end_pause_0", bus.pause, 0);
    check("wd_timeout_sticky", bus.hs_timeout, 1);
    bus.hs_req = 1;
    @(negedge clk);
    check("wd_timeout_cleared", bus.hs_timeout, 0);
    bus.hs_req = 0;
    repeat (3) @(negedge clk);
    $display("seq watchdog: %0d grant cycles", cnt);

    // Reset arriving while the high-score side owns the RAM.
    bus.vblank = 0; bus.hs_req = 1;
    repeat (3) @(negedge clk);
    bus.vblank = 1;
    wait_grant(k);
    check("rst_grant_seen", bus.hs_grant, 1);
    reset = 1'b1; #1;
    check("rst_grant_low", bus.hs_grant, 0);
    check("rst_cpu_owns", bus.ram_addr, 12'h0AB);
    check("rst_pause_low", bus.pause, 0);
    bus.hs_req = 0;
    @(negedge clk);
    reset = 1'b0;
    $display("seq reset-in-grant: grant=%0b", bus.hs_grant);

    // Random traffic against the model.
    begin
      int vbl_timer = 5;
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        check("rnd_grant", bus.hs_grant, (m.phase == P_GRANT));
        check("rnd_pause", bus.pause, m.pause);
        check("rnd_dim", bus.dim_video, m.dim);
        check("rnd_timeout", bus.hs_timeout, m.timeout);
        check("rnd_ram_addr", bus.ram_addr, (m.phase == P_GRANT) ? bus.hs_addr : bus.cpu_addr);
        check("rnd_ram_din", bus.ram_din, (m.phase == P_GRANT) ? bus.hs_din : bus.cpu_din);
        check("rnd_ram_we", bus.ram_we, (m.phase == P_GRANT) ? bus.hs_we : bus.cpu_we);
        if ($urandom_range(0, 59) == 0) bus.hs_req = ~bus.hs_req;
        if (vbl_timer == 0) begin
          bus.vblank = ~bus.vblank;
          vbl_timer = $urandom_range(3, 30);
        end else begin
          vbl_timer--;
        end
        bus.pause_btn = ($urandom_range(0, 119) == 0);
        if ($urandom_range(0, 99) == 0) bus.osd_open = ~bus.osd_open;
        if ($urandom_range(0, 99) == 0) bus.osd_pause_en = ~bus.osd_pause_en;
        bus.hs_addr  = 12'($urandom);
        bus.hs_din   = 8'($urandom);
        bus.hs_we    = 1'($urandom);
        bus.cpu_addr = 12'($urandom);
        bus.cpu_din  = 8'($urandom);
        bus.cpu_we   = 1'($urandom);
        if (c % 500 == 499)
          $display("random block %0d: checks=%0d errors=%0d", c / 500, checks, errors);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
